reg_stack_ctrl: RTL

REG_STACK_CTRL -- requirements
Module: reg_stack_ctrl

---
 rtl/reg_stack_ctrl_if.sv | 28 ++
 rtl/reg_stack_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/reg_stack_ctrl_if.sv
// Request/status bundle between a register file and its frame-stack controller.
// The master side issues push/pop/err_clr; the slave side is the controller.
interface reg_stack_ctrl_if #(
  parameter int AW = 5
);
  logic          push;
  logic          pop;
  logic          err_clr;
  logic [AW-1:0] addr;
  logic          wren;
  logic          restore;
  logic [AW:0]   sp;
  logic          empty;
  logic          full;
  logic          busy;
  logic          ovf;
  logic          unf;

  modport master (
    output push, pop, err_clr,
    input  addr, wren, restore, sp, empty, full, busy, ovf, unf
  );

  modport slave (
    input  push, pop, err_clr,
    output addr, wren, restore, sp, empty, full, busy, ovf, unf
  );
endinterface

// File: rtl/reg_stack_ctrl.sv
// Frame-stack controller: sequences whole-register-file save (push) and restore (pop)
// through external synchronous-read stack RAMs, tracking occupancy and sticky errors.
module reg_stack_ctrl #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input logic            clk,
  input logic            rst_n,
  reg_stack_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    PUSH_WR,
    POP_RD,
    POP_WB
  } state_t;

  localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] SP_ONE  = (AW+1)'(1);

  state_t        state_q, state_d;
  logic [AW:0]   sp_q, sp_d;
  logic [AW:0]   sp_dec;
  logic [AW-1:0] addr_q, addr_d;
  logic          wren_q, wren_d;
  logic          restore_q, restore_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          empty_w, full_w;

  assign empty_w = (sp_q == '0);
  assign full_w  = (sp_q == SP_FULL);
  assign sp_dec  = sp_q - SP_ONE;

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    addr_d    = addr_q;
    wren_d    = 1'b0;
    restore_d = 1'b0;
    // A new error in the same cycle overrides the clear below.
    ovf_d     = ovf_q & ~bus.err_clr;
    unf_d     = unf_q & ~bus.err_clr;

    case (state_q)
      IDLE: begin
        if (bus.push) begin
          if (full_w) begin
            ovf_d = 1'b1;
          end else begin
            state_d = PUSH_WR;
            addr_d  = sp_q[AW-1:0];
            wren_d  = 1'b1;
          end
        end else if (bus.pop) begin
          if (empty_w) begin
            unf_d = 1'b1;
          end else begin
            state_d = POP_RD;
            sp_d    = sp_dec;
            addr_d  = sp_dec[AW-1:0];
          end
        end
      end
      PUSH_WR: begin
        sp_d    = sp_q + SP_ONE;
        state_d = IDLE;
      end
      POP_RD: begin
        // RAMs latch the address this cycle; their data is valid next cycle.
        restore_d = 1'b1;
        state_d   = POP_WB;
      end
      POP_WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sp_q      <= '0;
      addr_q    <= '0;
      wren_q    <= 1'b0;
      restore_q <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sp_q      <= sp_d;
      addr_q    <= addr_d;
      wren_q    <= wren_d;
      restore_q <= restore_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign bus.addr    = addr_q;
  assign bus.wren    = wren_q;
  assign bus.restore = restore_q;
  assign bus.sp      = sp_q;
  assign bus.empty   = empty_w;
  assign bus.full    = full_w;
  assign bus.busy    = (state_q != IDLE);
  assign bus.ovf     = ovf_q;
  assign bus.unf     = unf_q;

endmodule
